// File: rtl/aes_sbox_pipe.sv
// AES SubBytes / InvSubBytes per byte via GF((2^4)^2) inversion, 3 registered stages, 1 byte/cycle.
// Latency 3 cycles; ready_o falls when stage 1 is held by a stalled successor or during flush.
module aes_sbox_pipe (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       valid_i,
   output logic       ready_o,
   input  logic [7:0] data_i,
   input  logic       inv_i,
   input  logic       flush_i,
   output logic       valid_o,
   input  logic       ready_i,
   output logic [7:0] data_o
);

   // GF(2^4) arithmetic, field polynomial x^4 + x + 1
   function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p;
      logic [3:0] t;
      p = 4'h0;
      t = a;
      for (int k = 0; k < 4; k++) begin
         if (b[k]) p = p ^ t;
         t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
      end
      return p;
   endfunction

   function automatic logic [3:0] gf4_sq(input logic [3:0] a);
      return gf4_mul(a, a);
   endfunction

   // Extension polynomial is y^2 + y + {e}, so delta needs a constant multiply by {e}
   function automatic logic [3:0] gf4_mul_e(input logic [3:0] a);
      return gf4_mul(a, 4'he);
   endfunction

   // a^-1 = a^14; zero naturally maps to zero
   function automatic logic [3:0] gf4_inv(input logic [3:0] a);
      logic [3:0] a2;
      logic [3:0] a4;
      logic [3:0] a8;
      a2 = gf4_sq(a);
      a4 = gf4_sq(a2);
      a8 = gf4_sq(a4);
      return gf4_mul(gf4_mul(a2, a4), a8);
   endfunction

   function automatic logic [7:0] iso_map(input logic [7:0] a);
      logic       t_a;
      logic       t_b;
      logic       t_c;
      logic [3:0] hi;
      logic [3:0] lo;
      t_a   = a[1] ^ a[7];
      t_b   = a[5] ^ a[7];
      t_c   = a[4] ^ a[6];
      lo[0] = t_c ^ a[0] ^ a[5];
      lo[1] = a[1] ^ a[2];
      lo[2] = t_a;
      lo[3] = a[2] ^ a[4];
      hi[0] = t_c ^ a[5];
      hi[1] = t_a ^ t_c;
      hi[2] = t_b ^ a[2] ^ a[3];
      hi[3] = t_b;
      return {hi, lo};
   endfunction

   function automatic logic [7:0] iso_unmap(input logic [7:0] q);
      logic       t_a;
      logic       t_b;
      logic [7:0] a;
      t_a  = q[1] ^ q[7];
      t_b  = q[4] ^ q[5];
      a[0] = q[0] ^ q[4];
      a[1] = t_b ^ q[7];
      a[2] = t_a ^ t_b;
      a[3] = t_b ^ q[1] ^ q[6];
      a[4] = t_a ^ t_b ^ q[3];
      a[5] = t_b ^ q[2];
      a[6] = t_a ^ q[2] ^ q[3] ^ q[4];
      a[7] = t_b ^ q[2] ^ q[7];
      return a;
   endfunction

   function automatic logic [7:0] aff_fwd(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] aff_inv(input logic [7:0] b);
      return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
   endfunction

   logic       r_v1;
   logic       r_v2;
   logic       r_v3;
   logic [3:0] r1_hi;
   logic [3:0] r1_sum;
   logic [3:0] r1_delta;
   logic       r1_inv;
   logic [3:0] r2_hi;
   logic [3:0] r2_sum;
   logic [3:0] r2_dinv;
   logic       r2_inv;
   logic [7:0] r3_data;

   logic       w_adv1;
   logic       w_adv2;
   logic       w_adv3;
   logic       w_in_xfer;
   logic [7:0] w_pre;
   logic [7:0] w_map;
   logic [3:0] w_hi;
   logic [3:0] w_lo;
   logic [3:0] w_sum;
   logic [3:0] w_delta;
   logic [7:0] w_comb;
   logic [7:0] w_unmap;
   logic [7:0] w_out;

   // Handshake chain: each stage moves when its successor is empty or moving too
   assign w_adv3    = r_v3 & ready_i;
   assign w_adv2    = r_v2 & (~r_v3 | w_adv3);
   assign w_adv1    = r_v1 & (~r_v2 | w_adv2);
   assign ready_o   = ~flush_i & (~r_v1 | w_adv1);
   assign w_in_xfer = valid_i & ready_o;
   assign valid_o   = r_v3;
   assign data_o    = r3_data;

   assign w_pre   = inv_i ? aff_inv(data_i) : data_i;
   assign w_map   = iso_map(w_pre);
   assign w_hi    = w_map[7:4];
   assign w_lo    = w_map[3:0];
   assign w_sum   = w_hi ^ w_lo;
   assign w_delta = gf4_mul(w_sum, w_lo) ^ gf4_mul_e(gf4_sq(w_hi));

   assign w_comb  = {gf4_mul(r2_hi, r2_dinv), gf4_mul(r2_sum, r2_dinv)};
   assign w_unmap = iso_unmap(w_comb);
   assign w_out   = r2_inv ? w_unmap : aff_fwd(w_unmap);

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else begin
         if (w_in_xfer)   r_v1 <= 1'b1;
         else if (w_adv1) r_v1 <= 1'b0;
         if (w_adv1)      r_v2 <= 1'b1;
         else if (w_adv2) r_v2 <= 1'b0;
         if (w_adv2)      r_v3 <= 1'b1;
         else if (w_adv3) r_v3 <= 1'b0;
      end
   end

   // Datapath carries no reset; contents only matter under the matching valid bit
   always_ff @(posedge clk_i) begin
      if (w_in_xfer) begin
         r1_hi    <= w_hi;
         r1_sum   <= w_sum;
         r1_delta <= w_delta;
         r1_inv   <= inv_i;
      end
      if (w_adv1) begin
         r2_hi   <= r1_hi;
         r2_sum  <= r1_sum;
         r2_dinv <= gf4_inv(r1_delta);
         r2_inv  <= r1_inv;
      end
      if (w_adv2) begin
         r3_data <= w_out;
      end
   end

endmodule
